// File: rtl/sal_sched_pkg.sv
// Shared types and constants for the DDR2 per-channel command scheduler.
// Ports: none (package). Provides cmd_t, ras_n/cas_n/we_n encodings, A10 index.
// Default DRAM/DFI widths are defined here when the build does not supply them.

`ifndef DRAM_BA_WIDTH
  `define DRAM_BA_WIDTH 3
`endif
`ifndef DRAM_RA_WIDTH
  `define DRAM_RA_WIDTH 14
`endif
`ifndef DRAM_CA_WIDTH
  `define DRAM_CA_WIDTH 10
`endif
`ifndef DFI_CS_WIDTH
  `define DFI_CS_WIDTH 1
`endif
`ifndef DFI_BA_WIDTH
  `define DFI_BA_WIDTH 3
`endif
`ifndef DFI_ADDR_WIDTH
  `define DFI_ADDR_WIDTH 14
`endif
`ifndef T_RRD_WIDTH
  `define T_RRD_WIDTH 4
`endif
`ifndef T_CCD_WIDTH
  `define T_CCD_WIDTH 4
`endif
`ifndef T_WTR_WIDTH
  `define T_WTR_WIDTH 4
`endif
`ifndef T_RTW_WIDTH
  `define T_RTW_WIDTH 4
`endif

package sal_sched_pkg;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_RD,
    CMD_WR,
    CMD_PRE,
    CMD_REF
  } cmd_t;

  // {ras_n, cas_n, we_n}
  localparam logic [2:0] RCW_NOP = 3'b111;
  localparam logic [2:0] RCW_ACT = 3'b011;
  localparam logic [2:0] RCW_RD  = 3'b101;
  localparam logic [2:0] RCW_WR  = 3'b100;
  localparam logic [2:0] RCW_PRE = 3'b010;
  localparam logic [2:0] RCW_REF = 3'b001;

  // Auto-precharge / all-bank bit of the address bus.
  localparam int A10_BIT = 10;

  function automatic logic [2:0] cmd_rcw(cmd_t c);
    case (c)
      CMD_ACT: return RCW_ACT;
      CMD_RD:  return RCW_RD;
      CMD_WR:  return RCW_WR;
      CMD_PRE: return RCW_PRE;
      CMD_REF: return RCW_REF;
      default: return RCW_NOP;
    endcase
  endfunction

endpackage

// File: rtl/ddr_cmd_scheduler_if.sv
// Bank-controller side of the scheduler: per-bank request/grant vectors plus
// packed per-bank row/column addresses. master = bank controllers (drive req,
// ra, ca; receive gnt), slave = scheduler.

interface ddr_cmd_scheduler_if #(
  parameter int NUM_BANKS = 8,
  parameter int RA_W      = `DRAM_RA_WIDTH,
  parameter int CA_W      = `DRAM_CA_WIDTH
);
  logic [NUM_BANKS-1:0]      act_req, rd_req, wr_req, pre_req, ref_req;
  logic [NUM_BANKS-1:0]      act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic [NUM_BANKS*RA_W-1:0] ra;
  logic [NUM_BANKS*CA_W-1:0] ca;

  modport master (
    output act_req, rd_req, wr_req, pre_req, ref_req, ra, ca,
    input  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt
  );

  modport slave (
    input  act_req, rd_req, wr_req, pre_req, ref_req, ra, ca,
    output act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt
  );
endinterface

// File: rtl/sal_rr_arbiter.sv
// Per-class bank arbiter: N requests in, one-hot grant out (combinational).
// Ports: clk, rst_n (sync, active low), req, en (grant consumed), gnt.
// SAL_SCHED_RR_EN defined: round-robin, pointer moves past the granted bank on en.
// SAL_SCHED_RR_EN undefined: fixed priority, lowest index wins, no pointer.

module sal_rr_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

`ifdef SAL_SCHED_RR_EN
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    logic [PW-1:0] bidx;
    logic          found;
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    bidx  = '0;
    // N is a power of two, so the PW-bit add wraps modulo N.
    for (int i = 0; i < N; i++) begin
      bidx = ptr_q + PW'(i);
      if (!found && req[bidx]) begin
        found     = 1'b1;
        gnt[bidx] = 1'b1;
        ptr_d     = bidx + 1'b1;
      end
    end
    if (!en) ptr_d = ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  // Isolate the lowest set request bit.
  assign gnt = req & (~req + 1'b1);

  logic unused_sigs;
  assign unused_sigs = &{1'b0, clk, rst_n, en};
`endif

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// Per-channel DDR2 command scheduler: picks one REF/RD/WR/ACT/PRE per cycle,
// enforces t_rrd/t_ccd/t_wtr/t_rtw, registers the DFI command, makes rddata_en.
// Ports: clk, rst_n (sync active low), bank (if slave: req/gnt/ra/ca), t_* timings,
// dfi_rden_lat, DFI control outputs. Bank arbitration mode set by SAL_SCHED_RR_EN.

module ddr_cmd_scheduler
  import sal_sched_pkg::*;
#(
  parameter int NUM_BANKS   = 8,
  parameter int RDEN_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ddr_cmd_scheduler_if.slave         bank,
  input  logic [`T_RRD_WIDTH-1:0]    t_rrd,
  input  logic [`T_CCD_WIDTH-1:0]    t_ccd,
  input  logic [`T_WTR_WIDTH-1:0]    t_wtr,
  input  logic [`T_RTW_WIDTH-1:0]    t_rtw,
  input  logic [3:0]                 dfi_rden_lat,
  output logic                       dfi_cke,
  output logic [`DFI_CS_WIDTH-1:0]   dfi_cs_n,
  output logic                       dfi_ras_n,
  output logic                       dfi_cas_n,
  output logic                       dfi_we_n,
  output logic [`DFI_BA_WIDTH-1:0]   dfi_ba,
  output logic [`DFI_ADDR_WIDTH-1:0] dfi_addr,
  output logic                       dfi_odt,
  output logic                       dfi_rddata_en
);

  localparam int BA_W   = `DRAM_BA_WIDTH;
  localparam int RA_W   = `DRAM_RA_WIDTH;
  localparam int CA_W   = `DRAM_CA_WIDTH;
  localparam int CS_W   = `DFI_CS_WIDTH;
  localparam int DBA_W  = `DFI_BA_WIDTH;
  localparam int ADDR_W = `DFI_ADDR_WIDTH;
  // Room for the largest latency plus the full window length.
  localparam int SR_W   = 16 + RDEN_CYCLES;

  logic [`T_RRD_WIDTH-1:0] rrd_cnt_q, rrd_cnt_d;
  logic [`T_CCD_WIDTH-1:0] ccd_cnt_q, ccd_cnt_d;
  logic [`T_WTR_WIDTH-1:0] wtr_cnt_q, wtr_cnt_d;
  logic [`T_RTW_WIDTH-1:0] rtw_cnt_q, rtw_cnt_d;

  logic                 cke_q, cke_d;
  logic [CS_W-1:0]      cs_n_q, cs_n_d;
  logic [2:0]           rcw_q, rcw_d;
  logic [DBA_W-1:0]     ba_q, ba_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [SR_W-1:0]      sr_q, sr_d;

  logic                 rd_ok, wr_ok, act_ok;
  logic [NUM_BANKS-1:0] rd_req_ok, wr_req_ok, cas_req, act_req_ok;
  logic [NUM_BANKS-1:0] ref_sel, cas_sel, act_sel, pre_sel;
  logic                 ref_win, cas_win, act_win, pre_win;
  logic [NUM_BANKS-1:0] rd_gnt, wr_gnt;

  // Eligibility: a constrained command waits for all of its counters to drain.
  assign rd_ok      = (ccd_cnt_q == '0) && (wtr_cnt_q == '0);
  assign wr_ok      = (ccd_cnt_q == '0) && (rtw_cnt_q == '0);
  assign act_ok     = (rrd_cnt_q == '0);
  assign rd_req_ok  = rd_ok  ? bank.rd_req  : '0;
  assign wr_req_ok  = wr_ok  ? bank.wr_req  : '0;
  assign act_req_ok = act_ok ? bank.act_req : '0;
  assign cas_req    = rd_req_ok | wr_req_ok;

  // Class priority REF > CAS > ACT > PRE; blocked classes have empty req here.
  assign ref_win = |bank.ref_req;
  assign cas_win = !ref_win && (|cas_req);
  assign act_win = !ref_win && !cas_win && (|act_req_ok);
  assign pre_win = !ref_win && !cas_win && !act_win && (|bank.pre_req);

  sal_rr_arbiter #(.N(NUM_BANKS)) u_ref_arb (
    .clk(clk), .rst_n(rst_n), .req(bank.ref_req), .en(ref_win), .gnt(ref_sel));
  sal_rr_arbiter #(.N(NUM_BANKS)) u_cas_arb (
    .clk(clk), .rst_n(rst_n), .req(cas_req), .en(cas_win), .gnt(cas_sel));
  sal_rr_arbiter #(.N(NUM_BANKS)) u_act_arb (
    .clk(clk), .rst_n(rst_n), .req(act_req_ok), .en(act_win), .gnt(act_sel));
  sal_rr_arbiter #(.N(NUM_BANKS)) u_pre_arb (
    .clk(clk), .rst_n(rst_n), .req(bank.pre_req), .en(pre_win), .gnt(pre_sel));

  // A bank asserting both RD and WR gets the read; the write stays pending.
  assign rd_gnt       = cas_win ? (cas_sel & rd_req_ok) : '0;
  assign wr_gnt       = cas_win ? (cas_sel & wr_req_ok & ~rd_req_ok) : '0;
  assign bank.ref_gnt = ref_win ? ref_sel : '0;
  assign bank.rd_gnt  = rd_gnt;
  assign bank.wr_gnt  = wr_gnt;
  assign bank.act_gnt = act_win ? act_sel : '0;
  assign bank.pre_gnt = pre_win ? pre_sel : '0;

  always_comb begin
    logic [NUM_BANKS-1:0] gnt_all;
    logic [BA_W-1:0]      gnt_idx;
    logic [RA_W-1:0]      ra_sel;
    logic [CA_W-1:0]      ca_sel;
    cmd_t                 cmd_sel;

    gnt_all = bank.ref_gnt | rd_gnt | wr_gnt | bank.act_gnt | bank.pre_gnt;
    gnt_idx = '0;
    ra_sel  = '0;
    ca_sel  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (gnt_all[b]) begin
        gnt_idx = BA_W'(b);
        ra_sel  = bank.ra[b*RA_W +: RA_W];
        ca_sel  = bank.ca[b*CA_W +: CA_W];
      end
    end

    cmd_sel = CMD_NOP;
    if (ref_win)       cmd_sel = CMD_REF;
    else if (|rd_gnt)  cmd_sel = CMD_RD;
    else if (|wr_gnt)  cmd_sel = CMD_WR;
    else if (act_win)  cmd_sel = CMD_ACT;
    else if (pre_win)  cmd_sel = CMD_PRE;

    cke_d  = 1'b1;
    cs_n_d = ~CS_W'(1);   // only rank 0 selected
    rcw_d  = cmd_rcw(cmd_sel);
    ba_d   = '0;
    addr_d = '0;
    case (cmd_sel)
      CMD_ACT: begin
        ba_d   = DBA_W'(gnt_idx);
        addr_d = ADDR_W'(ra_sel);
      end
      CMD_RD, CMD_WR: begin
        ba_d            = DBA_W'(gnt_idx);
        addr_d          = ADDR_W'(ca_sel);
        addr_d[A10_BIT] = 1'b0;
      end
      CMD_PRE: ba_d = DBA_W'(gnt_idx);
      default: ;
    endcase

    // Counters load t-1 so the command is legal again exactly t cycles later.
    rrd_cnt_d = (rrd_cnt_q == '0) ? '0 : rrd_cnt_q - 1'b1;
    ccd_cnt_d = (ccd_cnt_q == '0) ? '0 : ccd_cnt_q - 1'b1;
    wtr_cnt_d = (wtr_cnt_q == '0) ? '0 : wtr_cnt_q - 1'b1;
    rtw_cnt_d = (rtw_cnt_q == '0) ? '0 : rtw_cnt_q - 1'b1;
    if (act_win) rrd_cnt_d = (t_rrd == '0) ? '0 : t_rrd - 1'b1;
    if (cas_win) ccd_cnt_d = (t_ccd == '0) ? '0 : t_ccd - 1'b1;
    if (|rd_gnt) rtw_cnt_d = (t_rtw == '0) ? '0 : t_rtw - 1'b1;
    if (|wr_gnt) wtr_cnt_d = (t_wtr == '0) ? '0 : t_wtr - 1'b1;

    // The RD leaves on the DFI next cycle; bit 0 of sr_q drives rddata_en,
    // so tagging at bit lat lands the window lat cycles after the command.
    sr_d = sr_q >> 1;
    if (|rd_gnt) sr_d = sr_d | (SR_W'({RDEN_CYCLES{1'b1}}) << dfi_rden_lat);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rrd_cnt_q <= '0;
      ccd_cnt_q <= '0;
      wtr_cnt_q <= '0;
      rtw_cnt_q <= '0;
      cke_q     <= 1'b0;
      cs_n_q    <= '1;
      rcw_q     <= RCW_NOP;
      ba_q      <= '0;
      addr_q    <= '0;
      sr_q      <= '0;
    end else begin
      rrd_cnt_q <= rrd_cnt_d;
      ccd_cnt_q <= ccd_cnt_d;
      wtr_cnt_q <= wtr_cnt_d;
      rtw_cnt_q <= rtw_cnt_d;
      cke_q     <= cke_d;
      cs_n_q    <= cs_n_d;
      rcw_q     <= rcw_d;
      ba_q      <= ba_d;
      addr_q    <= addr_d;
      sr_q      <= sr_d;
    end
  end

  assign dfi_cke       = cke_q;
  assign dfi_cs_n      = cs_n_q;
  assign dfi_ras_n     = rcw_q[2];
  assign dfi_cas_n     = rcw_q[1];
  assign dfi_we_n      = rcw_q[0];
  assign dfi_ba        = ba_q;
  assign dfi_addr      = addr_q;
  assign dfi_odt       = 1'b0;
  assign dfi_rddata_en = sr_q[0];

endmodule
